logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (1..64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in register stages (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream presents a, b, op.
REQ-006 SHALL have port in_ready  output  1  unit accepts the input this cycle.
REQ-007 SHALL have port op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port out_valid  output  1  result present on out.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 SHALL have port out  output  WIDTH  bitwise result.
REQ-013 SHALL have port out_zero  output  1  high when out is all zeros, qualified by out_valid.

Function
REQ-014 SHALL compute the result bitwise per op, combinationally at the input, and capture it into stage 0 on an input transfer (in_valid and in_ready).
REQ-015 SHALL implement STAGES registered stages, each holding a valid bit, a WIDTH-bit result and a zero flag; out, out_zero, out_valid come directly from the last stage.
REQ-016 SHALL advance a stage when it is valid and the next stage is empty or also advancing; the last stage advances when out_ready is high.
REQ-017 SHALL drive in_ready high when stage 0 is empty or stage 0 advances this cycle (full throughput, no bubbles, under continuous out_ready).
REQ-018 SHALL give latency of exactly STAGES cycles from input transfer to out_valid with out_ready held high.
REQ-019 SHALL hold out, out_zero and out_valid stable while out_valid is high and out_ready is low.
REQ-020 SHALL accept simultaneous input transfer and output transfer in the same cycle when the pipeline is full, without loss or duplication.
REQ-021 SHALL preserve result order; every accepted input yields exactly one output.
REQ-022 SHALL ignore a, b, op when in_valid is low or in_ready is low.

Reset
REQ-023 SHALL clear all stage valid bits, results and zero flags asynchronously when rst_n is low: out_valid=0, out=0, out_zero=0, in_ready=1 after release.
REQ-024 SHALL discard all in-flight results on reset asserted mid-operation; no output from pre-reset inputs after release.
REQ-025 SHALL resume accepting input on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when macro LOGIC_GATE_UNIT_COUNT_EN is defined, add output op_count (16 bits) counting output transfers, saturating at 0xFFFF, reset to 0.
REQ-027 SHALL, when LOGIC_GATE_UNIT_COUNT_EN is undefined, omit op_count and its counter entirely; all other behaviour unchanged.

Structure
REQ-028 SHALL place the op encoding (enum of AND/OR/XOR/NAND) and WIDTH/STAGES defaults in shared package logic_gate_pkg.
REQ-029 SHALL implement one pipeline stage as sub-module lgu_stage (valid, data, zero flag, advance logic), instantiated STAGES times via generate.

Verification
REQ-030 SHALL verify truth table: WIDTH=8, STAGES=2, a=0xF0, b=0xCC, op=00/01/10/11 -> out=0xC0/0xFC/0x3C/0x3F, each 2 cycles after transfer.
REQ-031 SHALL verify zero flag: a=0x0F, b=0xF0, op=00 -> out=0x00, out_zero=1; op=01 -> out=0xFF, out_zero=0.
REQ-032 SHALL verify backpressure: stream 6 inputs, out_ready low for 4 cycles -> in_ready drops after 2 accepted with pipeline full, out held, all 6 results in order, none lost.
REQ-033 SHALL verify throughput: continuous in_valid and out_ready for 16 vectors -> 16 results on 16 consecutive cycles after 2-cycle latency.
REQ-034 SHALL verify reset mid-operation: assert rst_n low with 2 results in flight -> out_valid=0 immediately, no stale results after release.
REQ-035 SHALL verify, with LOGIC_GATE_UNIT_COUNT_EN defined, 10 output transfers -> op_count=10; counter forced near 0xFFFF saturates at 0xFFFF.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op encoding and parameter defaults.
package logic_gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;
  localparam int COUNT_W    = 16;

endpackage

// File: rtl/lgu_stage.sv
// One elastic pipeline stage: valid bit, result and zero flag, reloaded
// whenever the stage is empty or its contents move on downstream.
module lgu_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             up_zero_i,
  input  logic             down_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             load;

  // Empty or advancing: the slot is free for whatever upstream offers.
  assign load = ~valid_q | down_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    if (load) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
        zero_d = up_zero_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/logic_gate_unit.sv
// Pipelined bitwise AND/OR/XOR/NAND unit with valid/ready handshakes.
// Define LOGIC_GATE_UNIT_COUNT_EN to add the saturating op_count output.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
`ifdef LOGIC_GATE_UNIT_COUNT_EN
  ,
  output logic [COUNT_W-1:0] op_count
`endif
);

  op_e              op_sel;
  logic [WIDTH-1:0] res;
  logic [STAGES:0]  rdy;
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_zero;
  logic [WIDTH-1:0] stg_data [STAGES];

  assign op_sel = op_e'(op);

  always_comb begin
    res = '0;
    case (op_sel)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      default: res = '0;
    endcase
  end

  // rdy[i]: stage i can take new data. Computed from the registered valids in
  // one block so the ready path is a single ripple rather than a port loop.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = rdy[i+1] | ~stg_valid[i];
    end
  end

  assign in_ready = rdy[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      lgu_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .up_valid_i  (in_valid),
        .up_data_i   (res),
        .up_zero_i   (res == '0),
        .down_ready_i(rdy[i+1]),
        .valid_o     (stg_valid[i]),
        .data_o      (stg_data[i]),
        .zero_o      (stg_zero[i])
      );
    end else begin : g_next
      lgu_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .up_valid_i  (stg_valid[i-1]),
        .up_data_i   (stg_data[i-1]),
        .up_zero_i   (stg_zero[i-1]),
        .down_ready_i(rdy[i+1]),
        .valid_o     (stg_valid[i]),
        .data_o      (stg_data[i]),
        .zero_o      (stg_zero[i])
      );
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign out       = stg_data[STAGES-1];
  assign out_zero  = stg_zero[STAGES-1] & stg_valid[STAGES-1];

`ifdef LOGIC_GATE_UNIT_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign op_count = count_q;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit (WIDTH=8, STAGES=2); the op_count
// checks are built only when LOGIC_GATE_UNIT_COUNT_EN is defined.
module tb_logic_gate_unit;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         out_zero;
`ifdef LOGIC_GATE_UNIT_COUNT_EN
  logic [15:0]  op_count;
`endif

  logic_gate_unit #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_zero (out_zero)
`ifdef LOGIC_GATE_UNIT_COUNT_EN
    ,
    .op_count (op_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for one cycle; push the expectation if it was taken.
  task automatic send(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] ex, output bit acc);
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    @(negedge clk);
    acc = in_ready;
    if (acc) sb.push_back('{ex, (ex == '0), cyc, lat_chk});
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_retry(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [W-1:0] ex);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      send(o, va, vb, ex, acc);
      tries++;
    end
    if (!acc) fail_now("send_accept");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) fail_now("drain");
  endtask

  // Monitor: every presented result is compared against the queue head; it is
  // popped only when the downstream actually takes it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected no output (cycle %0d)", out, cyc);
      end else begin
        chk("out", out, sb[0].res);
        chk("out_zero", out_zero, sb[0].zero);
        if (out_ready) begin
          if (sb[0].lat) chk("latency", cyc - sb[0].acc, S);
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backpressure vectors with hand-computed results.
  logic [1:0]   bp_op [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [W-1:0] bp_a  [6] = '{8'hAA, 8'hAA, 8'h12, 8'hFF, 8'h81, 8'hF0};
  logic [W-1:0] bp_b  [6] = '{8'h55, 8'h55, 8'h34, 8'h0F, 8'h18, 8'hF0};
  logic [W-1:0] bp_e  [6] = '{8'h00, 8'hFF, 8'h26, 8'hF0, 8'h99, 8'h00};

  initial begin
    bit acc;
    int base;
    logic [W-1:0] ta, tb;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    step();

    // Truth table, back to back with fixed latency
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send_retry(2'b00, 8'hF0, 8'hCC, 8'hC0);
    send_retry(2'b01, 8'hF0, 8'hCC, 8'hFC);
    send_retry(2'b10, 8'hF0, 8'hCC, 8'h3C);
    send_retry(2'b11, 8'hF0, 8'hCC, 8'h3F);
    // Zero flag
    send_retry(2'b00, 8'h0F, 8'hF0, 8'h00);
    send_retry(2'b01, 8'h0F, 8'hF0, 8'hFF);
    drain();

    // Backpressure: out_ready low for 4 cycles while 6 inputs stream
    lat_chk = 1'b0;
    fork
      begin
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k >= 2) chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, (k >= 2));
          step();
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) send_retry(bp_op[i], bp_a[i], bp_b[i], bp_e[i]);
      end
    join
    drain();

    // Throughput: 16 vectors on consecutive cycles
    lat_chk = 1'b1;
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      ta = 8'(i * 13 + 7);
      tb = ~8'(i * 5);
      send(2'(i), ta, tb, model(2'(i), ta, tb), acc);
      chk("tp_in_ready", acc, 1);
    end
    drain();
    chk("tp_count", n_out - base, 16);

    // Reset with two results in flight
    lat_chk = 1'b0;
    out_ready = 1'b0;
    send_retry(2'b01, 8'h11, 8'h22, 8'h33);
    send_retry(2'b10, 8'h5A, 8'hFF, 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_midrst_idle", out_valid, 0);
      step();
    end
    lat_chk = 1'b1;
    send_retry(2'b11, 8'h00, 8'h00, 8'hFF);
    drain();

`ifdef LOGIC_GATE_UNIT_COUNT_EN
    for (int i = 0; i < 9; i++) send_retry(2'b10, 8'(i), 8'h0F, 8'(i) ^ 8'h0F);
    drain();
    chk("op_count_10", op_count, 16'd10);
    lat_chk = 1'b0;
    for (int i = 0; i < 65525; i++) send_retry(2'b00, 8'(i), 8'hA5, 8'(i) & 8'hA5);
    drain();
    chk("op_count_max", op_count, 16'hFFFF);
    for (int i = 0; i < 5; i++) send_retry(2'b01, 8'(i), 8'h40, 8'(i) | 8'h40);
    drain();
    chk("op_count_sat", op_count, 16'hFFFF);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
